// File: rtl/mario_vertical_motion_if.sv
`default_nettype none
// ============================================================================
// Module      : mario_vertical_motion_if
// Description : Bundle of frame strobe, key, velocity and collision inputs
//               plus the position/status outputs of the vertical motion block.
// Revision    : 1.0 - initial release
// ============================================================================
interface mario_vertical_motion_if;
   logic               frame_clk;
   logic        [7:0]  keycode;
   logic        [7:0]  keycode2;
   logic signed [31:0] Y_Velocity;
   logic        [9:0]  floor_y;
   logic        [9:0]  ceil_y;
   logic        [9:0]  Mario_Y_Pos;
   logic               current_jumping;
   logic               landed;
   logic               bonk;
   logic               fell_off;

   // Environment side: supplies stimulus, observes position and events
   modport master (
      output frame_clk, keycode, keycode2, Y_Velocity, floor_y, ceil_y,
      input  Mario_Y_Pos, current_jumping, landed, bonk, fell_off
   );

   // Motion block side
   modport slave (
      input  frame_clk, keycode, keycode2, Y_Velocity, floor_y, ceil_y,
      output Mario_Y_Pos, current_jumping, landed, bonk, fell_off
   );
endinterface
`default_nettype wire

// File: rtl/mario_vertical_motion.sv
`default_nettype none
// ============================================================================
// Module      : mario_vertical_motion
// Description : Integrates per-frame vertical velocity into Mario's feet row,
//               resolving floor landings, ceiling bonks and fall-offs.
// Revision    : 1.0 - initial release
// ============================================================================
module mario_vertical_motion #(
   parameter logic [9:0] Y_INIT   = 10'd400,
   parameter logic [9:0] Y_MAX    = 10'd479,
   parameter logic [7:0] JUMP_KEY = 8'h1A
) (
   input  logic                    Clk,
   input  logic                    Reset,
   mario_vertical_motion_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_GROUNDED = 2'd0,
      ST_AIRBORNE = 2'd1,
      ST_LANDED   = 2'd2,
      ST_DEAD     = 2'd3
   } state_t;

   state_t             r_state;
   logic        [9:0]  r_pos;
   logic               r_jumping;
   logic               r_landed;
   logic               r_bonk;
   logic               r_fell;
   logic               r_armed;
   logic               r_frame_prev;

   state_t             w_state_nxt;
   logic        [9:0]  w_pos_nxt;
   logic               w_landed_nxt;
   logic               w_bonk_nxt;
   logic               w_fell_nxt;
   logic               w_launch;

   logic               w_tick;
   logic               w_key_hit;
   logic signed [6:0]  w_vel_sat;
   logic signed [11:0] w_vel12;
   logic signed [11:0] w_next_y;
   logic signed [11:0] w_ymax12;
   logic signed [11:0] w_floor12;
   logic signed [11:0] w_ceil12;
   logic               w_vel_pos;
   logic               w_vel_neg;

   assign w_tick    = bus.frame_clk & ~r_frame_prev;
   assign w_key_hit = (bus.keycode == JUMP_KEY) || (bus.keycode2 == JUMP_KEY);

   // Clamp the jump FSM velocity to the 7-bit signed range used for motion
   always_comb begin
      if (bus.Y_Velocity > 32'sd63)
         w_vel_sat = 7'sd63;
      else if (bus.Y_Velocity < -32'sd64)
         w_vel_sat = 7'b100_0000;
      else
         w_vel_sat = bus.Y_Velocity[6:0];
   end

   assign w_vel12   = {{5{w_vel_sat[6]}}, w_vel_sat};
   assign w_next_y  = $signed({2'b00, r_pos}) + w_vel12;
   assign w_ymax12  = $signed({2'b00, Y_MAX});
   assign w_floor12 = $signed({2'b00, bus.floor_y});
   assign w_ceil12  = $signed({2'b00, bus.ceil_y});
   assign w_vel_pos = ~w_vel_sat[6] && (w_vel_sat != 7'sd0);
   assign w_vel_neg = w_vel_sat[6];

   // Next-state, next-position and event decode; only acts on a frame tick
   always_comb begin
      w_state_nxt  = r_state;
      w_pos_nxt    = r_pos;
      w_landed_nxt = 1'b0;
      w_bonk_nxt   = 1'b0;
      w_fell_nxt   = 1'b0;
      w_launch     = 1'b0;
      if (w_tick) begin
         case (r_state)
            ST_GROUNDED: begin
               if (r_armed && w_key_hit) begin
                  w_state_nxt = ST_AIRBORNE;
                  w_launch    = 1'b1;
               end else if (bus.floor_y > r_pos) begin
                  w_state_nxt = ST_AIRBORNE;
               end
            end
            ST_AIRBORNE: begin
               if (w_next_y > w_ymax12) begin
                  w_pos_nxt   = Y_MAX;
                  w_fell_nxt  = 1'b1;
                  w_state_nxt = ST_DEAD;
               end else if (w_vel_pos && (w_next_y >= w_floor12)) begin
                  w_pos_nxt    = bus.floor_y;
                  w_landed_nxt = 1'b1;
                  w_state_nxt  = ST_LANDED;
               end else if (w_vel_neg && (bus.ceil_y != 10'd0) && (w_next_y <= w_ceil12)) begin
                  // ceil_y of zero means open sky, so no bonk is possible
                  w_pos_nxt  = bus.ceil_y;
                  w_bonk_nxt = 1'b1;
               end else if (w_next_y < 12'sd0) begin
                  w_pos_nxt = 10'd0;
               end else begin
                  w_pos_nxt = w_next_y[9:0];
               end
            end
            ST_LANDED: begin
               w_state_nxt = ST_GROUNDED;
            end
            default: begin
               w_state_nxt = ST_DEAD;
            end
         endcase
      end
   end

   // State, position and registered event pulses
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state      <= ST_GROUNDED;
         r_pos        <= Y_INIT;
         r_jumping    <= 1'b0;
         r_landed     <= 1'b0;
         r_bonk       <= 1'b0;
         r_fell       <= 1'b0;
         r_frame_prev <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pos        <= w_pos_nxt;
         r_jumping    <= (w_state_nxt == ST_AIRBORNE);
         r_landed     <= w_landed_nxt;
         r_bonk       <= w_bonk_nxt;
         r_fell       <= w_fell_nxt;
         r_frame_prev <= bus.frame_clk;
      end
   end

   // Jump re-arm: a held key must be released before it can launch again
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         r_armed <= 1'b1;
      else if (!w_key_hit)
         r_armed <= 1'b1;
      else if (w_launch)
         r_armed <= 1'b0;
   end

   assign bus.Mario_Y_Pos     = r_pos;
   assign bus.current_jumping = r_jumping;
   assign bus.landed          = r_landed;
   assign bus.bonk            = r_bonk;
   assign bus.fell_off        = r_fell;

endmodule
`default_nettype wire

// File: doc/mario_vertical_motion.md
MARIO_VERTICAL_MOTION -- requirements
Module: mario_vertical_motion

Interface
REQ-001 Parameter Y_INIT, default 10'd400, meaning Mario_Y_Pos value (feet row) after reset.
REQ-002 Parameter Y_MAX, default 10'd479, meaning lowest on-screen row; passing it is a fall-off.
REQ-003 Parameter JUMP_KEY, default 8'h1A, meaning keycode that launches a jump.
REQ-004 Clk  input  1  system clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 frame_clk  input  1  frame strobe, same as the one clocking the velocity FSM; only its rising edge matters.
REQ-007 keycode, keycode2  input  8 each  current key codes.
REQ-008 Y_Velocity  input  32 signed  per-frame vertical velocity from the jump FSM; negative is up.
REQ-009 floor_y  input  10  row of the floor surface under Mario.
REQ-010 ceil_y  input  10  row of the lowest overhead obstacle; 0 means none.
REQ-011 Mario_Y_Pos  output  10  current feet row.
REQ-012 current_jumping  output  1  high while airborne; this signal feeds back to the jump FSM.
REQ-013 landed, bonk, fell_off  output  1 each  single-Clk-cycle event pulses.

Function
REQ-014 The block SHALL detect frame_clk rising edges with a registered previous-value flop.
- A "tick" is one Clk cycle wide.
- At most one position update SHALL occur per tick.

REQ-015 The FSM states SHALL be GROUNDED, AIRBORNE, LANDED and DEAD.
- current_jumping SHALL be 1 only in AIRBORNE (registered).

REQ-016 Velocity SHALL be saturated to [-64, +63] and sign-extended to 12 bits.
- next_y = Mario_Y_Pos + sat(Y_Velocity), computed in 12-bit signed.

REQ-017 GROUNDED, on a tick:
- If armed=1 and (keycode or keycode2) == JUMP_KEY: go to AIRBORNE and clear armed.
- Else if floor_y > Mario_Y_Pos: go to AIRBORNE (walk-off fall).
- Else: hold position.
- Between ticks: hold.

REQ-018 AIRBORNE, on a tick, checks in this priority order:
- (a) next_y > Y_MAX: Mario_Y_Pos = Y_MAX, fell_off pulse, go to DEAD.
- (b) velocity > 0 and next_y >= floor_y: Mario_Y_Pos = floor_y, landed pulse, go to LANDED.
- (c) velocity < 0 and next_y <= ceil_y: Mario_Y_Pos = ceil_y, bonk pulse, stay in AIRBORNE.
- (d) next_y < 0: Mario_Y_Pos = 0, stay in AIRBORNE.
- (e) otherwise: Mario_Y_Pos = next_y.
- Velocity 0 SHALL leave the position unchanged and the block in AIRBORNE (this covers the launch-frame lag of the jump FSM).

REQ-019 LANDED SHALL hold for exactly one tick (current_jumping=0, so the jump FSM returns to GROUND), then go to GROUNDED.
- No position change in LANDED.

REQ-020 armed SHALL be set on any Clk cycle in which neither keycode input equals JUMP_KEY.
- A held key SHALL NOT relaunch after landing.

REQ-021 DEAD SHALL hold Mario_Y_Pos and keep current_jumping=0 until Reset.

REQ-022 Pulses SHALL be registered and high for exactly one Clk cycle, in the cycle after the deciding tick.

REQ-023 Mario_Y_Pos and current_jumping SHALL update in the same Clk cycle as the pulses.

Reset
REQ-024 When Reset is low, asynchronously:
- State = GROUNDED.
- Mario_Y_Pos = Y_INIT.
- current_jumping, landed, bonk and fell_off = 0.
- armed = 1; frame edge flop = 0.

REQ-025 Reset asserted mid-air SHALL abort the jump with no pulse emitted.

Verification
REQ-026 Reset low with Y_INIT=400 -> Mario_Y_Pos=400, all flags 0, state GROUNDED.
REQ-027 Grounded at 400, floor_y=400, keycode=8'h1A, tick -> current_jumping=1; next ticks with vel 0, -10, -8 -> Mario_Y_Pos 400, 390, 382.
REQ-028 Airborne at 396, vel +6, floor_y=400 -> Mario_Y_Pos=400, landed pulse, LANDED then GROUNDED. With 8'h1A held throughout -> no relaunch until the key is released for at least one cycle and pressed again.
REQ-029 Airborne at 385, vel -8, ceil_y=380 -> Mario_Y_Pos=380, one bonk pulse, current_jumping stays 1.
REQ-030 Grounded at 400, floor_y changed to 430, no key, tick -> current_jumping=1; then vel +1 -> Mario_Y_Pos 401.
REQ-031 Airborne at 476, vel +6, floor_y=500 -> Mario_Y_Pos=479, fell_off pulse, DEAD. Further ticks -> no change. Reset low -> Mario_Y_Pos=400, GROUNDED.
